// File: rtl/vscale_fregfile_wb.sv
// FP register-file write-side controller: merges EX single-cycle results and FPU responses onto one write port.
// Result reaches the array one cycle after selection; a colliding FPU result parks in a skid register (ready low while full).
module vscale_fregfile_wb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_issue_valid,
    input  logic            i_issue_multi,
    input  logic [4:0]      i_issue_rd,
    input  logic            i_issue_rd_en,
    input  logic [2:0]      i_issue_rs_en,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    input  logic [4:0]      i_ra3,
    output logic            o_stall_issue,
    input  logic            i_ex_valid,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_data,
    output logic            o_ex_stall,
    input  logic            i_fpu_resp_valid,
    input  logic [4:0]      i_fpu_resp_rd,
    input  logic [XLEN-1:0] i_fpu_resp_data,
    output logic            o_fpu_resp_ready,
    output logic            o_wen,
    output logic [4:0]      o_wa,
    output logic [XLEN-1:0] o_wd,
    output logic [1:0]      o_bypass_rs1,
    output logic [1:0]      o_bypass_rs2,
    output logic [1:0]      o_bypass_rs3,
    output logic [XLEN-1:0] o_bypass_data0,
    output logic [XLEN-1:0] o_bypass_data1
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_skid_valid;
    logic [4:0]      r_skid_rd;
    logic [XLEN-1:0] r_skid_data;
    logic [31:0]     r_pending;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_ex_stall;

    logic            w_fpu_fire;
    logic            w_ex_take;
    logic            w_skid_drain;
    logic            w_skid_lose;
    logic            w_skid_load;
    logic            w_wb_valid_nxt;
    logic [4:0]      w_wb_rd_nxt;
    logic [XLEN-1:0] w_wb_data_nxt;
    logic            w_raw_hazard;
    logic            w_issue_set;
    logic [31:0]     w_pending_nxt;

    assign w_fpu_fire   = i_fpu_resp_valid & ~r_skid_valid;
    assign w_ex_take    = i_ex_valid & ~r_ex_stall;
    assign w_skid_drain = r_skid_valid & ~w_ex_take;
    assign w_skid_lose  = r_skid_valid & w_ex_take;

    always_comb begin
        w_wb_valid_nxt = 1'b0;
        w_wb_rd_nxt    = r_wb_rd;
        w_wb_data_nxt  = r_wb_data;
        w_skid_load    = 1'b0;
        if (r_ex_stall && r_skid_valid) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = r_skid_rd;
            w_wb_data_nxt  = r_skid_data;
        end else if (w_ex_take) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = i_ex_rd;
            w_wb_data_nxt  = i_ex_data;
            w_skid_load    = w_fpu_fire;
        end else if (r_skid_valid) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = r_skid_rd;
            w_wb_data_nxt  = r_skid_data;
        end else if (w_fpu_fire) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = i_fpu_resp_rd;
            w_wb_data_nxt  = i_fpu_resp_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_wb_valid_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
            r_wb_data  <= w_wb_data_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_skid_valid <= 1'b0;
            r_skid_rd    <= '0;
            r_skid_data  <= '0;
        end else if (w_skid_load) begin
            r_skid_valid <= 1'b1;
            r_skid_rd    <= i_fpu_resp_rd;
            r_skid_data  <= i_fpu_resp_data;
        end else if (w_skid_drain) begin
            r_skid_valid <= 1'b0;
        end
    end

    // Stall EX for one cycle once the parked result has lost STARVE_LIMIT times.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
            r_ex_stall   <= 1'b0;
        end else if (w_skid_drain) begin
            r_starve_cnt <= '0;
            r_ex_stall   <= 1'b0;
        end else if (w_skid_lose) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
            r_ex_stall   <= (r_starve_cnt == LIMIT_M1);
        end
    end

    assign w_raw_hazard = (i_issue_rs_en[0] & r_pending[i_ra1]) |
                          (i_issue_rs_en[1] & r_pending[i_ra2]) |
                          (i_issue_rs_en[2] & r_pending[i_ra3]);
    assign o_stall_issue = i_issue_valid &
                           (w_raw_hazard | (i_issue_rd_en & r_pending[i_issue_rd]));
    assign w_issue_set = i_issue_valid & ~o_stall_issue & i_issue_multi & i_issue_rd_en;

    // Set is applied after clear so a same-cycle reissue of the same rd stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_fpu_fire)
            w_pending_nxt[i_fpu_resp_rd] = 1'b0;
        if (w_issue_set)
            w_pending_nxt[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    function automatic logic [1:0] f_bypass_sel(input logic [4:0] ra, input logic wb_v,
                                                input logic [4:0] wb_rd, input logic sk_v,
                                                input logic [4:0] sk_rd);
        logic [1:0] sel;
        sel[1] = sk_v & (ra == sk_rd);
        sel[0] = wb_v & (ra == wb_rd) & ~sel[1];
        return sel;
    endfunction

    assign o_bypass_rs1 = f_bypass_sel(i_ra1, r_wb_valid, r_wb_rd, r_skid_valid, r_skid_rd);
    assign o_bypass_rs2 = f_bypass_sel(i_ra2, r_wb_valid, r_wb_rd, r_skid_valid, r_skid_rd);
    assign o_bypass_rs3 = f_bypass_sel(i_ra3, r_wb_valid, r_wb_rd, r_skid_valid, r_skid_rd);

    assign o_ex_stall       = r_ex_stall;
    assign o_fpu_resp_ready = ~r_skid_valid;
    assign o_wen            = r_wb_valid;
    assign o_wa             = r_wb_rd;
    assign o_wd             = r_wb_data;
    assign o_bypass_data0   = r_wb_data;
    assign o_bypass_data1   = r_skid_data;

endmodule

// File: tb/tb_vscale_fregfile_wb.sv
// Bench for vscale_fregfile_wb: directed vector table, starvation and reset sequences, random run against a model.
module tb_vscale_fregfile_wb;

    localparam int XLEN = 32;
    localparam int LIM  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid, issue_multi, issue_rd_en;
    logic [4:0]      issue_rd;
    logic [2:0]      issue_rs_en;
    logic [4:0]      ra1, ra2, ra3;
    logic            stall_issue;
    logic            ex_valid;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            ex_stall;
    logic            fpu_resp_valid;
    logic [4:0]      fpu_resp_rd;
    logic [XLEN-1:0] fpu_resp_data;
    logic            fpu_resp_ready;
    logic            wen;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
    logic [1:0]      bypass_rs1, bypass_rs2, bypass_rs3;
    logic [XLEN-1:0] bypass_data0, bypass_data1;

    always #5 clk = ~clk;

    vscale_fregfile_wb #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_issue_valid(issue_valid), .i_issue_multi(issue_multi), .i_issue_rd(issue_rd),
        .i_issue_rd_en(issue_rd_en), .i_issue_rs_en(issue_rs_en),
        .i_ra1(ra1), .i_ra2(ra2), .i_ra3(ra3), .o_stall_issue(stall_issue),
        .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_data(ex_data), .o_ex_stall(ex_stall),
        .i_fpu_resp_valid(fpu_resp_valid), .i_fpu_resp_rd(fpu_resp_rd),
        .i_fpu_resp_data(fpu_resp_data), .o_fpu_resp_ready(fpu_resp_ready),
        .o_wen(wen), .o_wa(wa), .o_wd(wd),
        .o_bypass_rs1(bypass_rs1), .o_bypass_rs2(bypass_rs2), .o_bypass_rs3(bypass_rs3),
        .o_bypass_data0(bypass_data0), .o_bypass_data1(bypass_data1)
    );

    typedef struct {
        logic iv; logic im; logic [4:0] ird; logic ird_en; logic [2:0] irs;
        logic [4:0] a1; logic [4:0] a2; logic [4:0] a3;
        logic exv; logic [4:0] exrd; logic [31:0] exd;
        logic fv; logic [4:0] frd; logic [31:0] fd;
        logic e_si; logic e_exst; logic e_rdy; logic e_wen; logic [4:0] e_wa; logic [31:0] e_wd;
        logic [1:0] e_b1; logic [1:0] e_b2; logic [1:0] e_b3; logic [31:0] e_bd1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: the write result in WB, the parked FPU result and how often it lost.
    logic        m_wb_v, m_pk_v;
    logic [4:0]  m_wb_rd, m_pk_rd;
    logic [31:0] m_wb_d, m_pk_d;
    int          m_losses;
    bit          m_pend [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_multi = v.im; issue_rd = v.ird; issue_rd_en = v.ird_en;
        issue_rs_en = v.irs; ra1 = v.a1; ra2 = v.a2; ra3 = v.a3;
        ex_valid = v.exv; ex_rd = v.exrd; ex_data = v.exd;
        fpu_resp_valid = v.fv; fpu_resp_rd = v.frd; fpu_resp_data = v.fd;
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    task automatic model_reset();
        m_wb_v = 0; m_pk_v = 0; m_wb_rd = 0; m_pk_rd = 0; m_wb_d = 0; m_pk_d = 0; m_losses = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    function automatic logic m_ex_stall();
        return m_pk_v && (m_losses >= LIM);
    endfunction

    function automatic logic m_stall_issue();
        logic h;
        h = (issue_rs_en[0] && m_pend[ra1]) || (issue_rs_en[1] && m_pend[ra2]) ||
            (issue_rs_en[2] && m_pend[ra3]) || (issue_rd_en && m_pend[issue_rd]);
        return issue_valid && h;
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] ra);
        if (m_pk_v && ra == m_pk_rd) return 2'b10;
        if (m_wb_v && ra == m_wb_rd) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_update();
        bit ex_take, acc, iss;
        ex_take = ex_valid && !m_ex_stall();
        acc     = fpu_resp_valid && !m_pk_v;
        iss     = issue_valid && !m_stall_issue();
        if (acc) m_pend[fpu_resp_rd] = 0;
        if (iss && issue_multi && issue_rd_en) m_pend[issue_rd] = 1;
        if (m_pk_v && !ex_take) begin
            m_wb_v = 1; m_wb_rd = m_pk_rd; m_wb_d = m_pk_d; m_pk_v = 0; m_losses = 0;
        end else if (ex_take) begin
            m_wb_v = 1; m_wb_rd = ex_rd; m_wb_d = ex_data;
            if (m_pk_v) m_losses++;
            if (acc) begin
                m_pk_v = 1; m_pk_rd = fpu_resp_rd; m_pk_d = fpu_resp_data; m_losses = 0;
            end
        end else if (acc) begin
            m_wb_v = 1; m_wb_rd = fpu_resp_rd; m_wb_d = fpu_resp_data;
        end else begin
            m_wb_v = 0;
        end
    endtask

    task automatic check_model();
        logic [1:0] s1, s2, s3;
        s1 = m_sel(ra1); s2 = m_sel(ra2); s3 = m_sel(ra3);
        chk("m_stall_issue", 32'(stall_issue), 32'(m_stall_issue()));
        chk("m_ex_stall", 32'(ex_stall), 32'(m_ex_stall()));
        chk("m_ready", 32'(fpu_resp_ready), 32'(!m_pk_v));
        chk("m_wen", 32'(wen), 32'(m_wb_v));
        if (m_wb_v) begin
            chk("m_wa", 32'(wa), 32'(m_wb_rd));
            chk("m_wd", wd, m_wb_d);
            chk("m_bd0", bypass_data0, m_wb_d);
        end
        chk("m_byp1", 32'(bypass_rs1), 32'(s1));
        chk("m_byp2", 32'(bypass_rs2), 32'(s2));
        chk("m_byp3", 32'(bypass_rs3), 32'(s3));
        if (m_pk_v) chk("m_bd1", bypass_data1, m_pk_d);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tv [18];
    vec_t rv;
    logic [31:0] wq [$];
    logic [31:0] eq [$];
    int   k, stall_cnt, stall_at;

    initial begin
        // iv im ird en irs | a1 a2 a3 | exv exrd exd | fv frd fd || si exst rdy wen wa wd | b1 b2 b3 bd1
        tv[0]  = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0,0,0};
        tv[1]  = '{0,0,0,0,0, 0,0,0, 1,3,32'h3F800000, 0,0,0,            0,0,1,0,0,0,            0,0,0,0};
        tv[2]  = '{0,0,0,0,0, 3,0,0, 1,10,32'h11111111,1,9,32'h40000000, 0,0,1,1,3,32'h3F800000, 1,0,0,0};
        tv[3]  = '{0,0,0,0,0, 10,3,9,0,0,0,            0,0,0,            0,0,0,1,10,32'h11111111,1,0,2,32'h40000000};
        tv[4]  = '{0,0,0,0,0, 0,0,9, 0,0,0,            0,0,0,            0,0,1,1,9,32'h40000000, 0,0,1,0};
        tv[5]  = '{1,1,5,1,0, 0,0,0, 0,0,0,            0,0,0,            0,0,1,0,0,0,            0,0,0,0};
        tv[6]  = '{1,0,0,0,2, 0,5,0, 0,0,0,            0,0,0,            1,0,1,0,0,0,            0,0,0,0};
        tv[7]  = '{1,0,0,0,2, 0,5,0, 0,0,0,            0,0,0,            1,0,1,0,0,0,            0,0,0,0};
        tv[8]  = '{0,0,0,0,0, 0,5,0, 0,0,0,            1,5,32'h12345678, 0,0,1,0,0,0,            0,0,0,0};
        tv[9]  = '{1,0,0,0,2, 0,5,0, 0,0,0,            0,0,0,            0,0,1,1,5,32'h12345678, 0,1,0,0};
        tv[10] = '{1,1,4,1,0, 0,0,0, 0,0,0,            1,4,32'hAAAA0004, 0,0,1,0,0,0,            0,0,0,0};
        tv[11] = '{1,0,0,0,1, 4,0,0, 0,0,0,            0,0,0,            1,0,1,1,4,32'hAAAA0004, 1,0,0,0};
        tv[12] = '{1,0,4,1,0, 0,0,0, 0,0,0,            0,0,0,            1,0,1,0,0,0,            0,0,0,0};
        tv[13] = '{0,0,0,0,0, 0,0,0, 0,0,0,            1,4,32'h5,        0,0,1,0,0,0,            0,0,0,0};
        tv[14] = '{1,0,0,0,7, 4,4,4, 0,0,0,            0,0,0,            0,0,1,1,4,32'h5,        1,1,1,0};
        tv[15] = '{0,0,0,0,0, 0,0,0, 1,7,32'h70,       1,7,32'h77,       0,0,1,0,0,0,            0,0,0,0};
        tv[16] = '{0,0,0,0,0, 7,0,0, 0,0,0,            0,0,0,            0,0,0,1,7,32'h70,       2,0,0,32'h77};
        tv[17] = '{0,0,0,0,0, 7,0,0, 0,0,0,            0,0,0,            0,0,1,1,7,32'h77,       1,0,0,0};

        reset = 1'b1;
        drive(idle_vec());
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_wen", 32'(wen), 0);
        chk("rst_wa", 32'(wa), 0);
        chk("rst_wd", wd, 0);
        chk("rst_bd0", bypass_data0, 0);
        chk("rst_bd1", bypass_data1, 0);
        chk("rst_ex_stall", 32'(ex_stall), 0);
        chk("rst_stall_issue", 32'(stall_issue), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d_stall_issue", i), 32'(stall_issue), 32'(tv[i].e_si));
            chk($sformatf("v%0d_ex_stall", i), 32'(ex_stall), 32'(tv[i].e_exst));
            chk($sformatf("v%0d_ready", i), 32'(fpu_resp_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tv[i].e_wen));
            if (tv[i].e_wen) begin
                chk($sformatf("v%0d_wa", i), 32'(wa), 32'(tv[i].e_wa));
                chk($sformatf("v%0d_wd", i), wd, tv[i].e_wd);
                chk($sformatf("v%0d_bd0", i), bypass_data0, tv[i].e_wd);
            end
            chk($sformatf("v%0d_byp1", i), 32'(bypass_rs1), 32'(tv[i].e_b1));
            chk($sformatf("v%0d_byp2", i), 32'(bypass_rs2), 32'(tv[i].e_b2));
            chk($sformatf("v%0d_byp3", i), 32'(bypass_rs3), 32'(tv[i].e_b3));
            if (tv[i].e_b1[1] | tv[i].e_b2[1] | tv[i].e_b3[1])
                chk($sformatf("v%0d_bd1", i), bypass_data1, tv[i].e_bd1);
            tick();
        end

        // EX held valid while an FPU result is parked: must stall EX exactly once and lose nothing.
        k = 0; stall_cnt = 0; stall_at = -1;
        for (int it = 0; it < 14; it++) begin
            rv = idle_vec();
            rv.exv = 1; rv.exrd = 5'd1; rv.exd = 32'h1000 + 32'(k);
            if (it == 0) begin rv.fv = 1; rv.frd = 5'd2; rv.fd = 32'h200; end
            drive(rv);
            #1;
            check_model();
            if (wen) wq.push_back(wd);
            if (ex_stall) begin stall_cnt++; stall_at = it; end
            else k++;
            tick();
        end
        for (int it = 0; it < 3; it++) begin
            drive(idle_vec());
            #1;
            check_model();
            if (wen) wq.push_back(wd);
            tick();
        end
        chk("starve_stall_cycles", 32'(stall_cnt), 1);
        chk("starve_stall_at", 32'(stall_at), LIM + 1);
        for (int j = 0; j < k; j++) begin
            eq.push_back(32'h1000 + 32'(j));
            if (j == LIM) eq.push_back(32'h200);
        end
        chk("starve_nwrites", 32'(wq.size()), 32'(eq.size()));
        for (int j = 0; j < eq.size() && j < wq.size(); j++)
            chk($sformatf("starve_write%0d", j), wq[j], eq[j]);

        for (int it = 0; it < 500; it++) begin
            rv = idle_vec();
            rv.iv = 1'($urandom_range(0, 1)); rv.im = 1'($urandom_range(0, 1));
            rv.ird = 5'($urandom_range(0, 7)); rv.ird_en = 1'($urandom_range(0, 1));
            rv.irs = 3'($urandom_range(0, 7));
            rv.a1 = 5'($urandom_range(0, 7)); rv.a2 = 5'($urandom_range(0, 7));
            rv.a3 = 5'($urandom_range(0, 7));
            rv.exv = ($urandom_range(0, 3) != 0); rv.exrd = 5'($urandom_range(0, 7));
            rv.exd = $urandom;
            rv.fv = 1'($urandom_range(0, 1)); rv.frd = 5'($urandom_range(0, 7));
            rv.fd = $urandom;
            drive(rv);
            #1;
            check_model();
            tick();
        end

        // Reset in the middle of a parked result and a pending f7.
        drive(idle_vec());
        #1;
        tick();
        rv = idle_vec();
        rv.iv = 1; rv.im = 1; rv.ird = 5'd7; rv.ird_en = 1;
        rv.exv = 1; rv.exrd = 5'd8; rv.exd = 32'hDEAD0008;
        rv.fv = 1; rv.frd = 5'd9; rv.fd = 32'hBEEF0009;
        drive(rv);
        #1;
        check_model();
        tick();
        drive(idle_vec());
        #1;
        chk("pre_rst_ready", 32'(fpu_resp_ready), 0);
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rv = idle_vec();
        rv.iv = 1; rv.irs = 3'b001; rv.a1 = 5'd7;
        drive(rv);
        #1;
        chk("mrst_wen", 32'(wen), 0);
        chk("mrst_wa", 32'(wa), 0);
        chk("mrst_wd", wd, 0);
        chk("mrst_bd0", bypass_data0, 0);
        chk("mrst_bd1", bypass_data1, 0);
        chk("mrst_ex_stall", 32'(ex_stall), 0);
        chk("mrst_ready", 32'(fpu_resp_ready), 1);
        chk("mrst_stall_issue_f7", 32'(stall_issue), 0);
        chk("mrst_byp1", 32'(bypass_rs1), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vscale_fregfile_wb.md
Name: vscale_fregfile_wb

Overview:
- Write-side controller for the FP register file.
- Merges two result sources onto the single FP register-file write port:
  - single-cycle FP ops from EX;
  - multi-cycle FPU responses over a valid/ready handshake.
- Tracks in-flight multi-cycle destinations in a scoreboard.
- Drives the register file's wen/wa/wd and its bypass selects and data. Read-side hazards are resolved either by bypass or by stalling issue.

Parameters:
- XLEN, 32, data width (equals XPR_LEN).
- STARVE_LIMIT, 4, cycles a parked FPU result may lose arbitration before EX is stalled.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  decode issuing an FP-related instruction this cycle
- issue_multi  input  1  issued op writes an FP rd through the multi-cycle FPU
- issue_rd  input  5  FP destination of the issued op
- issue_rd_en  input  1  issued op writes an FP rd
- issue_rs_en  input  3  per-source use flags [0]=ra1 [1]=ra2 [2]=ra3
- ra1, ra2, ra3  input  5 each  FP source addresses (same values presented to the register file)
- stall_issue  output  1  hold decode; issue is not accepted
- ex_valid  input  1  EX single-cycle FP result present
- ex_rd  input  5  EX destination
- ex_data  input  XLEN  EX result
- ex_stall  output  1  EX must hold its result; ex_valid is ignored this cycle
- fpu_resp_valid  input  1  FPU result present
- fpu_resp_rd  input  5  FPU destination
- fpu_resp_data  input  XLEN  FPU result
- fpu_resp_ready  output  1  controller accepts the FPU result
- wen  output  1  register-file write enable
- wa  output  5  register-file write address
- wd  output  XLEN  register-file write data
- bypass_rs1, bypass_rs2, bypass_rs3  output  2 each  [0] selects bypass_data0, [1] selects bypass_data1
- bypass_data0  output  XLEN  WB-stage data
- bypass_data1  output  XLEN  skid-register data

Behaviour:
- Reset (async): wb_valid=0, skid_valid=0, pending=0, starve count=0.
  - Outputs at reset: wen=0, wa=0, wd=0, bypass_data0=0, bypass_data1=0, ex_stall=0, stall_issue=0.
  - fpu_resp_ready=1 once reset is released.
  - A reset mid-operation drops all held results and pending bits.
- WB register (wb_valid/wb_rd/wb_data) is loaded each cycle from the selected source.
  - wen=wb_valid, wa=wb_rd, wd=wb_data, bypass_data0=wb_data.
  - Result to array write: 1 cycle.
- Skid register: skid_valid/skid_rd/skid_data; bypass_data1=skid_data. fpu_resp_ready = !skid_valid.
- Source selection, in priority order:
  1. ex_stall=1 and skid_valid: skid loads WB; skid clears.
  2. ex_valid and !ex_stall: EX loads WB. If an FPU response is accepted in the same cycle, it loads the skid.
  3. skid_valid: skid loads WB.
  4. fpu_resp_valid and ready: FPU loads WB directly.
  5. Otherwise wb_valid=0.
- Starvation control:
  - The counter increments each cycle skid_valid=1 and the skid does not drain; it clears when the skid drains.
  - ex_stall is registered; it asserts the cycle after the count reaches STARVE_LIMIT-1 and drops once the skid has drained.
- Scoreboard (32 pending bits):
  - Set on an accepted issue with issue_multi & issue_rd_en: bit issue_rd.
  - Cleared on an FPU handshake (fpu_resp_valid & fpu_resp_ready): bit fpu_resp_rd.
  - Same-cycle set and clear of the same bit: set wins.
- stall_issue (combinational): issue_valid and either
  - any enabled ra has its pending bit set, or
  - issue_rd_en and pending[issue_rd] (WAW).
- Bypass selects (combinational), per port N:
  - [0] = wb_valid & raN==wb_rd.
  - [1] = skid_valid & raN==skid_rd.
  - If both match, only [1] is asserted, because the skid entry is the younger value.
- Register f0 is a normal register; no zero handling.

Test Plan:
- Reset asserted mid-transfer with skid_valid=1 and pending[7]=1 -> next cycle all outputs 0, fpu_resp_ready=1, no stall on a read of f7.
- EX result rd=3 data=0x3F800000 -> next cycle wen=1 wa=3 wd=0x3F800000. Same cycle ra1=3 -> bypass_rs1=01, bypass_data0=0x3F800000.
- Multi-cycle issue rd=5, then next-cycle issue reading ra2=5 -> stall_issue=1 until the FPU response rd=5 is accepted. The response cycle clears the stall and WB writes f5 one cycle later.
- ex_valid and fpu_resp_valid together (FPU rd=9 data=0x40000000) -> EX written first; FPU value held in skid with fpu_resp_ready=0; ra3=9 gives bypass_rs3=10. f9 is written the next idle cycle.
- ex_valid held high continuously while skid is full -> ex_stall asserts after STARVE_LIMIT cycles; skid drains to WB; ex_stall drops; no EX result lost.
- Same cycle: FPU response rd=4 accepted and multi-cycle issue rd=4 -> pending[4] remains 1.
